// File: rtl/puertas_pkg.sv
// Shared encodings for the door controller and the door actuator stage.
package puertas_pkg;

  typedef enum logic [1:0] {
    PU_CERRADAS   = 2'b00,
    PU_ABIERTAS   = 2'b01,
    PU_CERRANDOSE = 2'b10,
    PU_ABRIENDOSE = 2'b11
  } puertas_e;

  // 2'b11 is deliberately absent: it must decode as no command.
  typedef enum logic [1:0] {
    CMD_NADA   = 2'b00,
    CMD_ABRIR  = 2'b01,
    CMD_CERRAR = 2'b10
  } cmd_e;

endpackage

// File: rtl/actuador_puertas_if.sv
// Controller <-> door actuator link: command and sensor in, status and drives out.
interface actuador_puertas_if #(
  parameter int PW = 4
);
  logic [1:0]    cmd;
  logic          sensor;
  logic [1:0]    puertas;
  logic          timeout;
  logic [PW-1:0] pos;
  logic          motor_abrir;
  logic          motor_cerrar;
  logic          cerradas_ok;

  modport master (
    output cmd, sensor,
    input  puertas, timeout, pos, motor_abrir, motor_cerrar, cerradas_ok
  );

  modport slave (
    input  cmd, sensor,
    output puertas, timeout, pos, motor_abrir, motor_cerrar, cerradas_ok
  );
endinterface

// File: rtl/temporizador_puertas.sv
// Saturating open-dwell counter; expirado flags that the dwell limit has been reached.
module temporizador_puertas #(
  parameter int T_OPEN = 50,
  parameter int DW     = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expirado
);
  localparam logic [DW-1:0] LIMITE = DW'(T_OPEN);

  logic [DW-1:0] dwell_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else if (clr) begin
      dwell_q <= '0;
    end else if (en && (dwell_q != LIMITE)) begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  assign expirado = (dwell_q == LIMITE);

endmodule

// File: rtl/actuador_puertas.sv
// Door mechanism model: status FSM (the status register is the state), position counter
// and dwell timer, with motor strobes and the closed-and-latched interlock.
module actuador_puertas
  import puertas_pkg::*;
#(
  parameter int T_MOVE = 8,
  parameter int T_OPEN = 50,
  parameter int PW     = 4,
  parameter int DW     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  actuador_puertas_if.slave  bus
);
  localparam logic [PW-1:0] POS_ABIERTA = PW'(T_MOVE);
  localparam logic [PW-1:0] POS_CASI    = PW'(T_MOVE - 1);

  puertas_e      state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic          abrir, cerrar;
  logic          dwell_clr, dwell_en, expirado;

  assign abrir  = (bus.cmd == CMD_ABRIR);
  assign cerrar = (bus.cmd == CMD_CERRAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PU_CERRADAS;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/pos_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    unique case (state_q)
      PU_CERRADAS: begin
        if (abrir) state_d = PU_ABRIENDOSE;
      end
      PU_ABRIENDOSE: begin
        if (cerrar && !bus.sensor) begin
          state_d = PU_CERRANDOSE;
        end else if (pos_q >= POS_CASI) begin
          // >= also catches a reversal taken at the fully-open position.
          pos_d   = POS_ABIERTA;
          state_d = PU_ABIERTAS;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      PU_ABIERTAS: begin
        if (cerrar) state_d = PU_CERRANDOSE;
      end
      PU_CERRANDOSE: begin
        if (bus.sensor || abrir) begin
          state_d = PU_ABRIENDOSE;
        end else if (pos_q <= PW'(1)) begin
          // <= also catches a close reversed at pos 0, keeping pos from wrapping.
          pos_d   = '0;
          state_d = PU_CERRADAS;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
      default: state_d = PU_CERRADAS;
    endcase
  end

  // Dwell only runs while resting open; anything else holds it at zero, so it
  // is already zero on the edge that enters the open state.
  assign dwell_en  = (state_q == PU_ABIERTAS);
  assign dwell_clr = !dwell_en || bus.sensor || abrir || cerrar;

  temporizador_puertas #(
    .T_OPEN (T_OPEN),
    .DW     (DW)
  ) u_temporizador (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (dwell_clr),
    .en       (dwell_en),
    .expirado (expirado)
  );

  assign bus.puertas      = state_q;
  assign bus.pos          = pos_q;
  assign bus.timeout      = (state_q == PU_ABIERTAS) && expirado;
  assign bus.motor_abrir  = (state_q == PU_ABRIENDOSE);
  assign bus.motor_cerrar = (state_q == PU_CERRANDOSE);
  assign bus.cerradas_ok  = (state_q == PU_CERRADAS) && (pos_q == '0);

endmodule

// File: tb/tb_actuador_puertas.sv
// Scoreboarded bench for actuador_puertas: a behavioural door model predicts each edge,
// the predicted output vector is queued and compared after the edge.
module tb_actuador_puertas;
  import puertas_pkg::*;

  localparam int T_MOVE = 4;
  localparam int T_OPEN = 6;
  localparam int PW     = 4;
  localparam int DW     = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  actuador_puertas_if #(.PW(PW)) bus ();

  actuador_puertas #(
    .T_MOVE (T_MOVE),
    .T_OPEN (T_OPEN),
    .PW     (PW),
    .DW     (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Door model, written from the behavioural description.
  logic [1:0] m_st;
  int         m_pos;
  int         m_dwell;
  logic [15:0] sb_q[$];
  string      fase = "reset";

  task automatic model_reset();
    m_st    = 2'b00;
    m_pos   = 0;
    m_dwell = 0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic s);
    logic ab, ce;
    ab = (c == 2'b01);
    ce = (c == 2'b10);
    case (m_st)
      2'b00: if (ab) m_st = 2'b11;
      2'b11: begin
        if (ce && !s) m_st = 2'b10;
        else begin
          m_pos = m_pos + 1;
          if (m_pos >= T_MOVE) begin
            m_pos   = T_MOVE;
            m_st    = 2'b01;
            m_dwell = 0;
          end
        end
      end
      2'b01: begin
        if (ce) begin
          m_st    = 2'b10;
          m_dwell = 0;
        end else if (s || ab) m_dwell = 0;
        else if (m_dwell < T_OPEN) m_dwell = m_dwell + 1;
      end
      default: begin
        if (s || ab) m_st = 2'b11;
        else begin
          m_pos = m_pos - 1;
          if (m_pos <= 0) begin
            m_pos = 0;
            m_st  = 2'b00;
          end
        end
      end
    endcase
  endtask

  function automatic logic [15:0] model_vec();
    logic to, ma, mc, ok;
    to = (m_st == 2'b01) && (m_dwell == T_OPEN);
    ma = (m_st == 2'b11);
    mc = (m_st == 2'b10);
    ok = (m_st == 2'b00) && (m_pos == 0);
    return {6'b0, m_st, to, 4'(m_pos), ma, mc, ok};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {6'b0, bus.puertas, bus.timeout, bus.pos, bus.motor_abrir, bus.motor_cerrar,
            bus.cerradas_ok};
  endfunction

  task automatic step(input logic [1:0] c, input logic s);
    logic [15:0] exp;
    bus.cmd    = c;
    bus.sensor = s;
    model_step(c, s);
    sb_q.push_back(model_vec());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard underflow", fase);
    end else begin
      exp = sb_q.pop_front();
      check(fase, dut_vec(), exp);
    end
    check({fase, "_motors"}, 16'(bus.motor_abrir & bus.motor_cerrar), 16'd0);
  endtask

  initial begin
    bus.cmd    = 2'b00;
    bus.sensor = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_vec", dut_vec(), model_vec());
    check("reset_ok", 16'(bus.cerradas_ok), 16'd1);
    rst_n = 1'b1;

    // Full open: ABRIENDOSE after edge 1, open after edge 5.
    fase = "open";
    step(2'b01, 1'b0);
    check("open_e1", 16'(bus.puertas), 16'(PU_ABRIENDOSE));
    repeat (T_MOVE) step(2'b00, 1'b0);
    check("open_e5", 16'(bus.puertas), 16'(PU_ABIERTAS));
    check("open_pos", 16'(bus.pos), 16'(T_MOVE));

    // Dwell expiry exactly T_OPEN cycles after opening, then held.
    fase = "dwell";
    repeat (T_OPEN - 1) step(2'b00, 1'b0);
    check("dwell_pre", 16'(bus.timeout), 16'd0);
    step(2'b00, 1'b0);
    check("dwell_to", 16'(bus.timeout), 16'd1);
    repeat (3) step(2'b00, 1'b0);
    check("dwell_hold", 16'(bus.timeout), 16'd1);

    // Close from fully open.
    fase = "close";
    step(2'b10, 1'b0);
    check("close_st", 16'(bus.puertas), 16'(PU_CERRANDOSE));
    check("close_to", 16'(bus.timeout), 16'd0);
    repeat (T_MOVE) step(2'b00, 1'b0);
    check("closed_ok", 16'(bus.cerradas_ok), 16'd1);
    step(2'b00, 1'b0);

    // Safety reversal at pos 2, then a close command reverses again.
    fase = "reversal";
    step(2'b01, 1'b0);
    repeat (T_MOVE) step(2'b00, 1'b0);
    step(2'b10, 1'b0);
    repeat (2) step(2'b00, 1'b0);
    check("rev_pos2", 16'(bus.pos), 16'd2);
    step(2'b00, 1'b1);
    check("rev_st", 16'(bus.puertas), 16'(PU_ABRIENDOSE));
    check("rev_pos", 16'(bus.pos), 16'd2);
    step(2'b00, 1'b0);
    step(2'b10, 1'b0);
    check("rev2_st", 16'(bus.puertas), 16'(PU_CERRANDOSE));
    repeat (T_MOVE) step(2'b00, 1'b0);

    // Sensor while open clears the dwell.
    fase = "dwell_clr";
    step(2'b01, 1'b0);
    repeat (T_MOVE) step(2'b00, 1'b0);
    repeat (T_OPEN - 1) step(2'b00, 1'b0);
    step(2'b00, 1'b1);
    check("dclr_to", 16'(bus.timeout), 16'd0);
    repeat (T_OPEN - 1) step(2'b00, 1'b0);
    check("dclr_pre", 16'(bus.timeout), 16'd0);
    step(2'b00, 1'b0);
    check("dclr_to6", 16'(bus.timeout), 16'd1);

    // cmd=11 held in every state behaves as no command.
    fase = "illegal";
    step(2'b10, 1'b1);
    repeat (T_MOVE + 2) step(2'b11, 1'b0);
    check("ill_closed", 16'(bus.puertas), 16'(PU_CERRADAS));
    step(2'b01, 1'b0);
    repeat (T_MOVE + T_OPEN + 2) step(2'b11, 1'b0);
    check("ill_open_to", 16'(bus.timeout), 16'd1);

    // Random traffic against the model.
    fase = "random";
    for (int i = 0; i < 500; i++) begin
      int r;
      logic [1:0] c;
      r = $urandom_range(0, 9);
      c = (r < 2) ? 2'b01 : (r < 4) ? 2'b10 : (r == 4) ? 2'b11 : 2'b00;
      step(c, ($urandom_range(0, 7) == 0));
    end
    fase = "settle";
    step(2'b10, 1'b0);
    repeat (T_MOVE + 1) step(2'b00, 1'b0);
    check("settle_ok", 16'(bus.cerradas_ok), 16'd1);

    // Asynchronous reset while opening at pos 3.
    fase = "async";
    step(2'b01, 1'b0);
    repeat (3) step(2'b00, 1'b0);
    check("async_pos3", 16'(bus.pos), 16'd3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_vec(), model_vec());
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b01, 1'b0);
    repeat (T_MOVE) step(2'b00, 1'b0);
    check("post_reset_open", 16'(bus.puertas), 16'(PU_ABIERTAS));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
